// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-class accumulator core: opcode values,
// controller state encoding and a small decode helper.
// Optional build macro SAP_FLAGS_EN enables the C/Z flags and JC/JZ.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    E0   = 3'd3,
    E1   = 3'd4,
    HALT = 3'd5
  } state_e;

  // Memory-operand instructions need a second execute cycle to use ram[MAR].
  function automatic logic needs_e1(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/sap_ram.sv
// Unified program/data RAM: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset so a loaded program
// survives a core reset.
module sap_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sap_core_param.sv
// Parametrised SAP-class accumulator CPU: controller FSM plus datapath
// (PC, MAR, IR, A, B, OUT register) around the unified RAM.
// Build macro SAP_FLAGS_EN: adds C/Z flags (updated by ADD/SUB) and the
// JC/JZ conditional jumps; without it opcodes 6/7 run as NOP.
module sap_core_param
  import sap_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_wdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          busy,
  output logic          halted
);

  state_e        state_r, next_s;
  logic [AW-1:0] pc_r, mar_r;
  logic [DW-1:0] ir_r, a_r, b_r, out_data_r;
  logic          out_valid_r, busy_r, halted_r;

  logic [3:0]    op_s;
  logic [AW-1:0] opd_s;
  logic [DW-1:0] ram_rdata_s;
  logic          busy_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_waddr_s;
  logic [DW-1:0] ram_wdata_s;
  logic [DW-1:0] add_s, sub_s;
`ifdef SAP_FLAGS_EN
  logic          c_r, z_r;
  logic          add_c_s;
`endif

  assign op_s   = ir_r[DW-1:DW-4];
  assign opd_s  = ir_r[AW-1:0];
  assign busy_s = (state_r == F0) || (state_r == F1) || (state_r == E0) || (state_r == E1);

  sap_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (mar_r),
    .rdata (ram_rdata_s)
  );

  // RAM write port mux: STA owns it in E1, the host only while idle/halted.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = prog_addr;
    ram_wdata_s = prog_wdata;
    if ((state_r == E1) && (op_s == OP_STA)) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = mar_r;
      ram_wdata_s = a_r;
    end else if (prog_we && !busy_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = prog_addr;
      ram_wdata_s = prog_wdata;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  // ALU: modular add/subtract of A and the RAM operand.
  always_comb begin
    sub_s = a_r - ram_rdata_s;
`ifdef SAP_FLAGS_EN
    {add_c_s, add_s} = {1'b0, a_r} + {1'b0, ram_rdata_s};
`else
    add_s = a_r + ram_rdata_s;
`endif
  end

  // Controller next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (run) next_s = F0; else next_s = IDLE;
      F0:      next_s = F1;
      F1:      next_s = E0;
      E0: begin
        if (op_s == OP_HLT) begin
          next_s = HALT;
        end else if (needs_e1(op_s)) begin
          next_s = E1;
        end else begin
          next_s = F0;
        end
      end
      E1:      next_s = F0;
      HALT:    if (run) next_s = F0; else next_s = HALT;
      default: next_s = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      busy_r   <= (next_s == F0) || (next_s == F1) || (next_s == E0) || (next_s == E1);
      halted_r <= (next_s == HALT);
    end
  end

  // Datapath registers: fetch, execute and the OUT port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= {AW{1'b0}};
      mar_r       <= {AW{1'b0}};
      ir_r        <= {DW{1'b0}};
      a_r         <= {DW{1'b0}};
      b_r         <= {DW{1'b0}};
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
`ifdef SAP_FLAGS_EN
      c_r         <= 1'b0;
      z_r         <= 1'b0;
`endif
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE, HALT: begin
          if (run) begin
            pc_r <= {AW{1'b0}};
            a_r  <= {DW{1'b0}};
            b_r  <= {DW{1'b0}};
`ifdef SAP_FLAGS_EN
            c_r  <= 1'b0;
            z_r  <= 1'b0;
`endif
          end
        end
        F0: mar_r <= pc_r;
        F1: begin
          ir_r <= ram_rdata_s;
          pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
        end
        E0: begin
          case (op_s)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_r <= opd_s;
            OP_LDI: a_r  <= {{(DW-AW){1'b0}}, opd_s};
            OP_JMP: pc_r <= opd_s;
            OP_OUT: begin
              out_data_r  <= a_r;
              out_valid_r <= 1'b1;
            end
`ifdef SAP_FLAGS_EN
            OP_JC:  if (c_r) pc_r <= opd_s;
            OP_JZ:  if (z_r) pc_r <= opd_s;
`endif
            default: ;
          endcase
        end
        E1: begin
          case (op_s)
            OP_LDA: a_r <= ram_rdata_s;
            OP_ADD: begin
              b_r <= ram_rdata_s;
              a_r <= add_s;
`ifdef SAP_FLAGS_EN
              c_r <= add_c_s;
              z_r <= (add_s == {DW{1'b0}});
`endif
            end
            OP_SUB: begin
              b_r <= ram_rdata_s;
              a_r <= sub_s;
`ifdef SAP_FLAGS_EN
              c_r <= (a_r >= ram_rdata_s);
              z_r <= (sub_s == {DW{1'b0}});
`endif
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_sap_core_param.sv
// Directed self-checking bench for sap_core_param. Expected OUT values are
// queued when a program is started and popped by a monitor on out_valid.
module tb_sap_core_param;
  import sap_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          halted;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic [DW-1:0] exp_q[$];

  sap_core_param #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every out_valid pulse consumes one expected value.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check("out_data_scoreboard", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
      pulses++;
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) load(i[AW-1:0], 8'h80);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_until_halt(input int max, output int cyc);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cyc = 1;
    while (!halted && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int cyc;
    int base;
    // Reset state
    @(negedge clk);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LDA 9, ADD A, OUT, HLT -> 0x1C + 0x0E = 0x2A in 15 cycles
    clear_ram();
    load(4'h0, 8'h09); load(4'h1, 8'h1A); load(4'h2, 8'hE0); load(4'h3, 8'hF0);
    load(4'h9, 8'h1C); load(4'hA, 8'h0E);
    exp_q.push_back(8'h2A);
    base = pulses;
    run_until_halt(40, cyc);
    check("add_cycles", cyc, 32'd15);
    check("add_out_data", {24'd0, out_data}, 32'h2A);
    check("add_pulses", pulses - base, 32'd1);
    check("add_b_reg", {24'd0, dut.b_r}, 32'h0E);
    check("hlt_pc", {28'd0, dut.pc_r}, 32'h4);
    check("halt_busy", {31'd0, busy}, 32'd0);

    // SUB 0x05 - 0x07 -> 0xFE (C=0, Z=0)
    clear_ram();
    load(4'h0, 8'h08); load(4'h1, 8'h29); load(4'h2, 8'hE0); load(4'h3, 8'hF0);
    load(4'h8, 8'h05); load(4'h9, 8'h07);
    exp_q.push_back(8'hFE);
    run_until_halt(40, cyc);
    check("sub_neg_a", {24'd0, dut.a_r}, 32'hFE);
`ifdef SAP_FLAGS_EN
    check("sub_neg_c", {31'd0, dut.c_r}, 32'd0);
    check("sub_neg_z", {31'd0, dut.z_r}, 32'd0);
`endif
    // SUB 0x07 - 0x07 -> 0 (C=1, Z=1)
    load(4'h8, 8'h07);
    exp_q.push_back(8'h00);
    run_until_halt(40, cyc);
    check("sub_zero_a", {24'd0, dut.a_r}, 32'h00);
    check("sub_zero_b", {24'd0, dut.b_r}, 32'h07);
`ifdef SAP_FLAGS_EN
    check("sub_zero_c", {31'd0, dut.c_r}, 32'd1);
    check("sub_zero_z", {31'd0, dut.z_r}, 32'd1);
`endif

    // LDI 3, STA F, LDA F, OUT, HLT: 3+4+4+3+3 cycles plus start
    clear_ram();
    load(4'h0, 8'h43); load(4'h1, 8'h3F); load(4'h2, 8'h0F); load(4'h3, 8'hE0);
    load(4'h4, 8'hF0);
    exp_q.push_back(8'h03);
    run_until_halt(60, cyc);
    check("sta_cycles", cyc, 32'd18);
    check("sta_ram_f", {24'd0, dut.u_ram.mem_r[15]}, 32'h03);
    check("sta_out_data", {24'd0, out_data}, 32'h03);

    // JMP loop over OUT, with prog_we held during busy
    clear_ram();
    load(4'h0, 8'h45); load(4'h1, 8'hE0); load(4'h2, 8'h51);
    repeat (3) exp_q.push_back(8'h05);
    base = pulses;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    prog_we = 1'b1; prog_addr = 4'h2; prog_wdata = 8'hF0;
    cyc = 0;
    while (pulses < base + 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    prog_we = 1'b0;
    check("jmp_loop_pulses", pulses - base, 32'd3);
    check("jmp_loop_busy", {31'd0, busy}, 32'd1);
    do_reset();
    check("busy_we_ignored", {24'd0, dut.u_ram.mem_r[2]}, 32'h51);
    check("jmp_q_empty", exp_q.size(), 32'd0);

    // PC wraps 0xF -> 0x0 over an all-NOP RAM
    clear_ram();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (44) @(negedge clk);
    check("pc_before_wrap", {28'd0, dut.pc_r}, 32'hF);
    repeat (3) @(negedge clk);
    check("pc_after_wrap", {28'd0, dut.pc_r}, 32'h0);
    do_reset();

    // Reset asserted while STA is in E1: no RAM write, everything cleared
    clear_ram();
    load(4'h0, 8'h47); load(4'h1, 8'h3C);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (6) @(negedge clk);
    check("sta_in_e1", {29'd0, dut.state_r}, {29'd0, E1});
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_e1_ram", {24'd0, dut.u_ram.mem_r[12]}, 32'h80);
    check("rst_e1_state", {29'd0, dut.state_r}, {29'd0, IDLE});
    check("rst_e1_busy", {31'd0, busy}, 32'd0);
    check("rst_e1_a", {24'd0, dut.a_r}, 32'h00);
    check("rst_e1_outs", {22'd0, out_data, out_valid, halted}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // JZ after 8-8 (Z=1): taken only with flags
    clear_ram();
    load(4'h0, 8'h08); load(4'h1, 8'h28); load(4'h2, 8'h76); load(4'h3, 8'h41);
    load(4'h4, 8'hE0); load(4'h5, 8'hF0); load(4'h6, 8'h42); load(4'h7, 8'h54);
    load(4'h8, 8'h09);
`ifdef SAP_FLAGS_EN
    exp_q.push_back(8'h02);
`else
    exp_q.push_back(8'h01);
`endif
    run_until_halt(80, cyc);
    check("jz_q_empty", exp_q.size(), 32'd0);

    // JC after 7-5 (C=1): taken only with flags
    load(4'h1, 8'h29); load(4'h2, 8'h66); load(4'h8, 8'h07); load(4'h9, 8'h05);
`ifdef SAP_FLAGS_EN
    exp_q.push_back(8'h02);
`else
    exp_q.push_back(8'h01);
`endif
    run_until_halt(80, cyc);
    check("jc_q_empty", exp_q.size(), 32'd0);
    check("jc_pc_after_hlt", {28'd0, dut.pc_r}, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
